// File: rtl/div_ctrl.sv
// Divide sequencer between execute stage and an iterative divider; fast-paths
// divide-by-zero and signed overflow, otherwise issues, waits and writes back.
//   state | meaning
//   IDLE  | no divide outstanding, accepts a request
//   ISSUE | div_req_o pulse with latched operands
//   WAIT  | waiting for divider result
//   DRAIN | flushed, swallowing the divider result
//   WB    | presenting result until writeback accepts
module div_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req_i,
  input  logic [2:0]  ex_op_code_i,
  input  logic [31:0] ex_data1_i,
  input  logic [31:0] ex_data2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        flush_i,
  output logic        div_req_o,
  output logic [31:0] div_data1_o,
  output logic [31:0] div_data2_o,
  output logic [2:0]  div_op_code_o,
  output logic [4:0]  div_reg_wr_addr_o,
  input  logic        div_res_ready_i,
  input  logic [31:0] div_res_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_ready_i,
  output logic        timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_WB} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_req_q, wb_valid_q, timeout_q;
  logic [31:0]      div_data1_q, div_data2_q, wb_data_q;
  logic [2:0]       div_op_q;
  logic [4:0]       div_rd_q, wb_rd_q;

  // Opcode bit1 selects remainder, bit0 selects unsigned.
  logic        is_rem, is_signed, div_zero, overflow, fast_hit;
  logic [31:0] fast_res;

  assign is_rem    = ex_op_code_i[1];
  assign is_signed = ~ex_op_code_i[0];
  assign div_zero  = (ex_data2_i == 32'h0);
  assign overflow  = is_signed && (ex_data1_i == 32'h8000_0000) && (ex_data2_i == 32'hFFFF_FFFF);
  assign fast_hit  = div_zero | overflow;

  always_comb begin
    fast_res = 32'h0;
    if (div_zero)      fast_res = is_rem ? ex_data1_i : 32'hFFFF_FFFF;
    else if (overflow) fast_res = is_rem ? 32'h0 : 32'h8000_0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_req_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      timeout_q   <= 1'b0;
      div_data1_q <= '0;
      div_data2_q <= '0;
      div_op_q    <= '0;
      div_rd_q    <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
    end else begin
      div_req_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ex_div_req_i && !flush_i) begin
            div_op_q    <= ex_op_code_i;
            div_data1_q <= ex_data1_i;
            div_data2_q <= ex_data2_i;
            div_rd_q    <= ex_rd_i;
            wb_rd_q     <= ex_rd_i;
            if (fast_hit) begin
              wb_data_q <= fast_res;
              state_q   <= S_WB;
            end else begin
              div_req_q <= 1'b1;
              state_q   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= flush_i ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (div_res_ready_i) begin
            if (flush_i) begin
              state_q <= S_IDLE;
            end else begin
              wb_data_q  <= div_res_i;
              wb_valid_q <= 1'b1;
              state_q    <= S_WB;
            end
          end else if (flush_i) begin
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (div_res_ready_i) begin
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          // Fast paths enter WB with valid low and raise it one cycle later.
          if (flush_i) begin
            wb_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end else if (!wb_valid_q) begin
            wb_valid_q <= 1'b1;
          end else if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The WB term also holds stall while a fast-path result is not yet valid.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      S_IDLE:          stall_o = ex_div_req_i & ~flush_i;
      S_ISSUE, S_WAIT: stall_o = 1'b1;
      S_WB:            stall_o = ~(wb_valid_q & wb_ready_i);
      S_DRAIN:         stall_o = ex_div_req_i;
      default:         stall_o = 1'b0;
    endcase
  end

  assign div_req_o         = div_req_q;
  assign div_data1_o       = div_data1_q;
  assign div_data2_o       = div_data2_q;
  assign div_op_code_o     = div_op_q;
  assign div_reg_wr_addr_o = div_rd_q;
  assign wb_valid_o        = wb_valid_q;
  assign wb_rd_o           = wb_rd_q;
  assign wb_data_o         = wb_data_q;
  assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: driver pushes expected writebacks, monitor
// pops on handshake; a divider model answers div_req_o after a set latency.
module tb_div_ctrl;
  localparam int TO = 40;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic clk = 1'b0, rst = 1'b1;
  logic ex_div_req_i = 1'b0, flush_i = 1'b0, div_res_ready_i = 1'b0, wb_ready_i = 1'b0;
  logic [2:0]  ex_op_code_i = '0;
  logic [31:0] ex_data1_i = '0, ex_data2_i = '0, div_res_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        div_req_o, stall_o, wb_valid_o, timeout_o;
  logic [31:0] div_data1_o, div_data2_o, wb_data_o;
  logic [2:0]  div_op_code_o;
  logic [4:0]  div_reg_wr_addr_o, wb_rd_o;

  div_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_div_req_i(ex_div_req_i), .ex_op_code_i(ex_op_code_i),
    .ex_data1_i(ex_data1_i), .ex_data2_i(ex_data2_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
    .div_req_o(div_req_o), .div_data1_o(div_data1_o), .div_data2_o(div_data2_o),
    .div_op_code_o(div_op_code_o), .div_reg_wr_addr_o(div_reg_wr_addr_o),
    .div_res_ready_i(div_res_ready_i), .div_res_i(div_res_i), .stall_o(stall_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_ready_i(wb_ready_i), .timeout_o(timeout_o));

  always #5 clk = ~clk;

  typedef struct {logic [4:0] rd; logic [31:0] data; int lat; int acc;} exp_t;
  exp_t sb_q[$];

  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int req_cnt = 0, tmo_cnt = 0, tmo_cyc = 0, div_lat = 1;
  int stray_req = 0, stray_done = 0;
  bit busy = 0, mute = 0, ready_lo = 0, ready_hi = 0, prev_valid = 0;
  logic [2:0]  exp_op;
  logic [31:0] exp_a, exp_b;
  logic [4:0]  exp_rd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural divide semantics, including the divide-by-zero and overflow rules.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit rem, sgn;
    longint sa, sb;
    rem = (op == OP_REM) || (op == OP_REMU);
    sgn = (op == OP_DIV) || (op == OP_REM);
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  always begin
    @(posedge clk);
    #2;
    wb_ready_i = ready_lo ? 1'b0 : (ready_hi ? 1'b1 : ($urandom_range(0, 2) != 0));
  end

  // Divider model: answers L cycles after the div_req_o cycle.
  always begin
    int lat;
    logic [31:0] res;
    @(negedge clk);
    if (stray_req != stray_done) begin
      stray_done = stray_req;
      @(posedge clk); #1;
      div_res_ready_i = 1'b1; div_res_i = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      div_res_ready_i = 1'b0;
    end else if (!rst && div_req_o && !mute) begin
      lat = div_lat;
      res = ref_div(div_op_code_o, div_data1_o, div_data2_o);
      repeat (lat) @(posedge clk);
      #1;
      div_res_ready_i = 1'b1; div_res_i = res;
      @(posedge clk); #1;
      div_res_ready_i = 1'b0; div_res_i = $urandom;
    end
  end

  always @(negedge clk) begin
    if (!rst && div_req_o) begin
      req_cnt++;
      chk("div_op", 32'(div_op_code_o), 32'(exp_op));
      chk("div_data1", div_data1_o, exp_a);
      chk("div_data2", div_data2_o, exp_b);
      chk("div_rd", 32'(div_reg_wr_addr_o), 32'(exp_rd));
    end
  end

  // Monitor: latency on valid rise, stable rd/data while valid, pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (timeout_o) begin
        tmo_cnt++;
        tmo_cyc = cyc;
        busy = 0;
      end
      if (wb_valid_o) begin
        if (sb_q.size() == 0) begin
          chk("wb_unexpected", 32'(wb_valid_o), 32'h0);
        end else begin
          if (!prev_valid) chk("wb_latency", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
          chk("wb_rd", 32'(wb_rd_o), 32'(sb_q[0].rd));
          chk("wb_data", wb_data_o, sb_q[0].data);
          if (wb_ready_i) begin
            void'(sb_q.pop_front());
            busy = 0;
          end
        end
      end
      if (busy && !(wb_valid_o && wb_ready_i)) chk("stall_busy", 32'(stall_o), 32'h1);
      prev_valid = wb_valid_o;
    end
  end

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input bit push, output int acc);
    @(posedge clk); #1;
    ex_div_req_i = 1'b1; ex_op_code_i = op; ex_data1_i = a; ex_data2_i = b; ex_rd_i = rd;
    exp_op = op; exp_a = a; exp_b = b; exp_rd = rd; div_lat = lat; acc = cyc;
    if (push) sb_q.push_back(exp_t'{rd, ref_div(op, a, b), is_fast(op, a, b) ? 2 : lat + 2, acc});
    @(negedge clk);
    chk("stall_accept", 32'(stall_o), 32'h1);
    @(posedge clk); #1;
    ex_div_req_i = 1'b0; ex_data1_i = $urandom; ex_data2_i = $urandom; busy = 1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
    chk("wb_done", 32'(sb_q.size()), 32'h0);
    sb_q.delete();
    busy = 0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat);
    int acc, base;
    base = req_cnt;
    start_op(op, a, b, rd, lat, 1, acc);
    wait_done();
    chk("div_req_count", 32'(req_cnt - base), is_fast(op, a, b) ? 32'h0 : 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, base, tbase;
    logic [2:0] op;
    logic [31:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_div_req", 32'(div_req_o), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_wb_data", wb_data_o, 32'h0);
    chk("rst_div_data1", div_data1_o, 32'h0);
    rst = 1'b0;

    // Stray divider result while idle is ignored.
    stray_req++;
    repeat (4) @(negedge clk);
    chk("stray_ready_wb", 32'(wb_valid_o), 32'h0);
    chk("stray_ready_stall", 32'(stall_o), 32'h0);

    run_op(OP_DIV, 32'd100, 32'd7, 5'd5, 3);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 4);
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd8, 2);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1);
    run_op(OP_REMU, 32'd123, 32'd0, 5'd0, 1);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd0, 6);

    for (int i = 0; i < 40; i++) begin
      op = OP_DIV + 3'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(1, 8));
    end

    // Writeback held off for 5 cycles, accepted on the 6th.
    ready_lo = 1;
    start_op(OP_DIV, 32'd100, 32'd7, 5'd5, 2, 1, acc);
    goto_cycle(acc + 6);
    @(negedge clk);
    chk("wb_hold_valid", 32'(wb_valid_o), 32'h1);
    chk("wb_hold_stall", 32'(stall_o), 32'h1);
    goto_cycle(acc + 9);
    ready_lo = 0; ready_hi = 1;
    goto_cycle(acc + 10);
    ready_hi = 0;
    @(negedge clk);
    chk("wb_drop_after_ready", 32'(wb_valid_o), 32'h0);
    chk("wb_hold_done", 32'(sb_q.size()), 32'h0);
    sb_q.delete(); busy = 0;

    // Flush 10 cycles after issue; a request waiting in DRAIN is taken once the divider answers.
    tbase = tmo_cnt;
    start_op(OP_DIV, 32'd1000, 32'd3, 5'd7, 15, 0, acc);
    goto_cycle(acc + 11);
    flush_i = 1'b1; busy = 0;
    goto_cycle(acc + 12);
    flush_i = 1'b0;
    @(negedge clk);
    chk("stall_drain_idle", 32'(stall_o), 32'h0);
    goto_cycle(acc + 13);
    base = req_cnt;
    ex_div_req_i = 1'b1; ex_op_code_i = OP_DIVU; ex_data1_i = 32'd50; ex_data2_i = 32'd5; ex_rd_i = 5'd9;
    exp_op = OP_DIVU; exp_a = 32'd50; exp_b = 32'd5; exp_rd = 5'd9; div_lat = 3; busy = 1;
    sb_q.push_back(exp_t'{5'd9, 32'd10, 5, acc + 17});
    @(negedge clk);
    chk("stall_drain_req", 32'(stall_o), 32'h1);
    goto_cycle(acc + 18);
    ex_div_req_i = 1'b0;
    wait_done();
    chk("drain_req_count", 32'(req_cnt - base), 32'h1);

    // Flush during ISSUE: the request pulse completes, no writeback follows.
    base = req_cnt;
    start_op(OP_REMU, 32'd77, 32'd5, 5'd3, 5, 0, acc);
    flush_i = 1'b1; busy = 0;
    goto_cycle(acc + 2);
    flush_i = 1'b0;
    goto_cycle(acc + 10);
    chk("issue_flush_req_count", 32'(req_cnt - base), 32'h1);
    chk("issue_flush_no_timeout", 32'(tmo_cnt - tbase), 32'h0);
    run_op(OP_REMU, 32'd77, 32'd5, 5'd3, 2);

    // Flush while presenting a fast-path result.
    ready_lo = 1;
    start_op(OP_DIVU, 32'd5, 32'd0, 5'd4, 1, 1, acc);
    goto_cycle(acc + 3);
    flush_i = 1'b1;
    goto_cycle(acc + 4);
    flush_i = 1'b0; sb_q.delete(); busy = 0;
    @(negedge clk);
    chk("wb_flush_drop", 32'(wb_valid_o), 32'h0);
    chk("wb_flush_stall", 32'(stall_o), 32'h0);
    ready_lo = 0;
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd12, 2);

    // Divider never answers.
    mute = 1;
    tbase = tmo_cnt;
    start_op(OP_DIV, 32'd9, 32'd2, 5'd1, 1, 0, acc);
    for (int i = 0; i < 100 && tmo_cnt == tbase; i++) @(negedge clk);
    chk("timeout_cycle", 32'(tmo_cyc - acc), 32'(2 + TO));
    @(negedge clk);
    chk("timeout_pulse_width", 32'(timeout_o), 32'h0);
    chk("timeout_count", 32'(tmo_cnt - tbase), 32'h1);
    busy = 0;

    // Reset mid-WAIT clears everything at once.
    start_op(OP_REM, 32'd1234, 32'd56, 5'd17, 1, 0, acc);
    goto_cycle(acc + 6);
    busy = 0; rst = 1'b1;
    #1;
    chk("mid_rst_div_req", 32'(div_req_o), 32'h0);
    chk("mid_rst_stall", 32'(stall_o), 32'h0);
    chk("mid_rst_wb_valid", 32'(wb_valid_o), 32'h0);
    chk("mid_rst_wb_data", wb_data_o, 32'h0);
    chk("mid_rst_wb_rd", 32'(wb_rd_o), 32'h0);
    chk("mid_rst_div_data1", div_data1_o, 32'h0);
    chk("mid_rst_div_data2", div_data2_o, 32'h0);
    chk("mid_rst_div_op", 32'(div_op_code_o), 32'h0);
    chk("mid_rst_div_rd", 32'(div_reg_wr_addr_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mute = 0;
    tbase = tmo_cnt;
    repeat (50) @(negedge clk);
    chk("no_timeout_after_reset", 32'(tmo_cnt - tbase), 32'h0);
    run_op(OP_DIV, 32'd100, 32'd7, 5'd5, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 40, max cycles in WAIT/DRAIN before abort.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have the ports below, listed as name, direction, width, meaning.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ex_div_req_i  in  1  execute stage presents a divide.
- ex_op_code_i  in  3  DIV/DIVU/REM/REMU (`defines` encodings).
- ex_data1_i  in  32  dividend.
- ex_data2_i  in  32  divisor.
- ex_rd_i  in  5  destination register.
- flush_i  in  1  pipeline flush, kills the in-flight divide.
- div_req_o  out  1  one-cycle request to divider.
- div_data1_o  out  32  dividend to divider.
- div_data2_o  out  32  divisor to divider.
- div_op_code_o  out  3  opcode to divider.
- div_reg_wr_addr_o  out  5  rd to divider.
- div_res_ready_i  in  1  divider result pulse.
- div_res_i  in  32  divider result.
- stall_o  out  1  hold execute stage.
- wb_valid_o  out  1  writeback result valid.
- wb_rd_o  out  5  writeback register.
- wb_data_o  out  32  writeback data.
- wb_ready_i  in  1  writeback accepts result.
- timeout_o  out  1  one-cycle abort pulse.

Function
REQ-004 SHALL implement states IDLE, ISSUE, WAIT, DRAIN, WB; all outputs registered except stall_o.
REQ-005 SHALL, in IDLE with ex_div_req_i=1 and flush_i=0, latch opcode, operands and rd.
REQ-006 SHALL fast-path divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend. Goes IDLE->WB next cycle; no div_req_o.
REQ-007 SHALL fast-path DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: DIV -> 0x80000000, REM -> 0. Goes IDLE->WB; no div_req_o.
REQ-008 SHALL otherwise go IDLE->ISSUE.
REQ-009 SHALL, in ISSUE, drive div_req_o=1 for exactly one cycle with latched operands, opcode and rd on the div_* outputs; then go to WAIT.
REQ-010 SHALL, in WAIT on div_res_ready_i=1 with flush_i=0, capture div_res_i into wb_data_o and go to WB.
REQ-011 SHALL, on flush_i=1 in ISSUE or WAIT without div_res_ready_i, go to DRAIN. In ISSUE, div_req_o still completes its pulse.
REQ-012 SHALL, on flush_i=1 and div_res_ready_i=1 in the same WAIT cycle, discard the result and go to IDLE.
REQ-013 SHALL, in DRAIN, discard the result on div_res_ready_i and go to IDLE; a new request is not accepted in that cycle.
REQ-014 SHALL, in WB, hold wb_valid_o=1 with stable wb_rd_o/wb_data_o until wb_ready_i=1, then go to IDLE. wb_valid_o drops the following cycle.
REQ-015 SHALL, on flush_i=1 in WB, drop wb_valid_o next cycle and go to IDLE without handshake.
REQ-016 SHALL drive stall_o combinationally as the OR of:
- IDLE & ex_div_req_i & !flush_i;
- ISSUE or WAIT;
- WB & !wb_ready_i;
- DRAIN & ex_div_req_i.
REQ-017 SHALL count cycles in WAIT/DRAIN with a counter cleared on entry. On reaching TIMEOUT_CYCLES it pulses timeout_o for 1 cycle and goes to IDLE; no writeback is produced.
REQ-018 SHALL ignore ex_div_req_i outside IDLE; it never accepts a second divide while one is outstanding.
REQ-019 SHALL produce a result with rd=0 like any other; suppressing the write to x0 is the register file's job.
REQ-020 SHALL give a latency from accept to wb_valid_o of 2 cycles for fast paths, and otherwise divider latency + 2.

Reset
REQ-021 SHALL, on rst=1, enter IDLE and clear state, counters, div_req_o, wb_valid_o, timeout_o, and all data/address outputs to 0, at any point including mid-divide.
REQ-022 SHALL ignore div_res_ready_i arriving after reset while in IDLE.

Verification
REQ-023 DIV 100/7, rd=5 -> one div_req_o pulse; later wb_valid_o=1, wb_rd_o=5, wb_data_o=14; stall_o high throughout.
REQ-024 REM 0xFFFFFFF9(-7)/2 -> wb_data_o=0xFFFFFFFF(-1); DIVU 5/0 -> wb_data_o=0xFFFFFFFF 2 cycles after accept, div_req_o never asserted.
REQ-025 DIV 0x80000000/0xFFFFFFFF -> wb_data_o=0x80000000 with no div_req_o; REM same operands -> 0.
REQ-026 flush_i 10 cycles after issue -> DRAIN; divider result discarded, wb_valid_o stays 0; next request accepted after divider ready.
REQ-027 wb_ready_i held 0 for 5 cycles in WB -> wb_valid_o/data stable, stall_o=1; ready on cycle 6 -> IDLE next cycle.
REQ-028 div_res_ready_i never asserted, TIMEOUT_CYCLES=40 -> timeout_o pulse 40 cycles after WAIT entry; also rst asserted mid-WAIT -> all outputs 0 immediately.
